// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state type and sizing helpers for the sequential divider
package div_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ITER,
    FIXUP,
    DONE
  } div_state_e;

  function automatic int div_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step: shift in a bit, trial-subtract the divisor
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   p_in,
  input  logic [WIDTH-1:0] m,
  input  logic             bit_in,
  output logic [WIDTH:0]   p_out,
  output logic             q_bit,
  output logic             borrow
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             unused_p_msb;

  // P stays below M, so its top bit is always clear before the shift
  assign unused_p_msb = p_in[WIDTH];

  always_comb begin
    shifted = {p_in[WIDTH-1:0], bit_in};
    diff    = {1'b0, shifted} - {2'b00, m};
    borrow  = diff[WIDTH+1];
    q_bit   = ~borrow;
    p_out   = borrow ? shifted : diff[WIDTH:0];
  end

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential restoring divider; define DIV_SIGNED_EN for two's complement operands
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadDivisor,
  input  logic             Run,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int CW = div_cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] qm_q, qm_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [CW-1:0]    count_q, count_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH:0]   step_p;
  logic             step_q;
  logic             step_borrow_unused;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_in   (p_q),
    .m      (m_q),
    .bit_in (qm_q[WIDTH-1]),
    .p_out  (step_p),
    .q_bit  (step_q),
    .borrow (step_borrow_unused)
  );

  always_comb begin
    state_d    = state_q;
    divisor_d  = divisor_q;
    dividend_d = dividend_q;
    qm_d       = qm_q;
    m_d        = m_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    p_d        = p_q;
    count_d    = count_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    div_zero_d = div_zero_q;
    case (state_q)
      IDLE: begin
        // divisor load lands before SETUP reads it, so a joint strobe divides S by itself
        if (LoadDivisor) divisor_d = S;
        if (Run) begin
          dividend_d = S;
          state_d    = SETUP;
        end
      end
      SETUP: begin
`ifdef DIV_SIGNED_EN
        qm_d   = dividend_q[WIDTH-1] ? -dividend_q : dividend_q;
        m_d    = divisor_q[WIDTH-1] ? -divisor_q : divisor_q;
        qneg_d = dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1];
        rneg_d = dividend_q[WIDTH-1];
`else
        qm_d   = dividend_q;
        m_d    = divisor_q;
        qneg_d = 1'b0;
        rneg_d = 1'b0;
`endif
        p_d        = '0;
        count_d    = CW'(WIDTH);
        div_zero_d = (divisor_q == '0);
        state_d    = ITER;
      end
      ITER: begin
        p_d     = step_p;
        qm_d    = {qm_q[WIDTH-2:0], step_q};
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = FIXUP;
      end
      FIXUP: begin
        if (div_zero_q) begin
          quot_d = '1;
          rem_d  = dividend_q;
        end else begin
          quot_d = qneg_q ? -qm_q : qm_q;
          rem_d  = rneg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
        end
        state_d = DONE;
      end
      DONE: begin
        if (LoadDivisor) divisor_d = S;
        if (!Run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      divisor_q  <= '0;
      dividend_q <= '0;
      qm_q       <= '0;
      m_q        <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      p_q        <= '0;
      count_q    <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      divisor_q  <= divisor_d;
      dividend_q <= dividend_d;
      qm_q       <= qm_d;
      m_q        <= m_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      p_q        <= p_d;
      count_q    <= count_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign Quotient  = quot_q;
  assign Remainder = rem_q;
  assign Divisor   = divisor_q;
  assign DivZero   = div_zero_q;
  assign Busy      = (state_q == SETUP) || (state_q == ITER) || (state_q == FIXUP);
  assign Done      = (state_q == DONE);

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - scoreboard bench for div_seq; honours DIV_SIGNED_EN when defined
module tb_div_seq;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         LoadDivisor;
  logic         Run;
  logic [W-1:0] S;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic [W-1:0] Divisor;
  logic         Busy;
  logic         Done;
  logic         DivZero;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [W-1:0] dvs;
    logic         dz;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  logic done_prev = 1'b0;

  div_seq #(.WIDTH(W)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .LoadDivisor (LoadDivisor),
    .Run         (Run),
    .S           (S),
    .Quotient    (Quotient),
    .Remainder   (Remainder),
    .Divisor     (Divisor),
    .Busy        (Busy),
    .Done        (Done),
    .DivZero     (DivZero)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.dvs = b;
    e.dz  = (b == 0);
    if (b == 0) begin
      e.q = '1;
      e.r = a;
    end else begin
`ifdef DIV_SIGNED_EN
      int sa;
      int sb;
      sa  = int'($signed(a));
      sb  = int'($signed(b));
      e.q = W'(sa / sb);
      e.r = W'(sa % sb);
`else
      e.q = a / b;
      e.r = a % b;
`endif
    end
    return e;
  endfunction

  always @(negedge Clk) begin
    if (Reset) begin
      done_prev = 1'b0;
    end else begin
      if (Done && !done_prev) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("quotient", Quotient, mon_e.q);
          chk("remainder", Remainder, mon_e.r);
          chk("divzero", DivZero, mon_e.dz);
          chk("divisor", Divisor, mon_e.dvs);
        end
      end
      done_prev = Done;
    end
  end

  task automatic do_div(input logic [W-1:0] dvs, input logic [W-1:0] dvd, input bit simul,
                        input int hold, input bit mid_load);
    logic [W-1:0] used;
    int n;
    int busy_n;
    bit got;
    bit ok;
    used = simul ? dvd : dvs;
    if (!simul) begin
      @(posedge Clk); #1;
      LoadDivisor = 1'b1;
      S = dvs;
      @(posedge Clk); #1;
      LoadDivisor = 1'b0;
    end
    sb_q.push_back(ref_div(dvd, used));
    @(posedge Clk); #1;
    Run = 1'b1;
    S = dvd;
    LoadDivisor = simul;
    n = 0;
    busy_n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge Clk);
      n++;
      #1;
      if (n == 1) begin
        LoadDivisor = 1'b0;
        S = W'($urandom);
      end
      if (mid_load && n == 4) begin
        LoadDivisor = 1'b1;
        S = ~used;
      end
      if (mid_load && n == 5) LoadDivisor = 1'b0;
      @(negedge Clk);
      if (Busy) busy_n++;
      if (Done) got = 1'b1;
    end
    chk("latency_edges", n, W + 3);
    chk("busy_cycles", busy_n, W + 2);
    if (hold > 0) begin
      ok = 1'b1;
      repeat (hold) begin
        @(negedge Clk);
        if (!Done || Busy) ok = 1'b0;
      end
      chk("run_hold_single", ok, 1);
      chk("divisor_kept", Divisor, used);
    end
    @(posedge Clk); #1;
    Run = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    chk("done_clears", Done, 0);
  endtask

  task automatic reset_mid_iter();
    int n;
    @(posedge Clk); #1;
    LoadDivisor = 1'b1;
    S = 8'h00;
    @(posedge Clk); #1;
    LoadDivisor = 1'b0;
    Run = 1'b1;
    S = 8'h55;
    for (n = 1; n <= 5; n++) @(posedge Clk);
    #1;
    Reset = 1'b1;
    Run = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_mid_quotient", Quotient, 0);
    chk("rst_mid_remainder", Remainder, 0);
    chk("rst_mid_divisor", Divisor, 0);
    chk("rst_mid_busy", Busy, 0);
    chk("rst_mid_done", Done, 0);
    chk("rst_mid_divzero", DivZero, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    Reset = 1'b1;
    LoadDivisor = 1'b0;
    Run = 1'b0;
    S = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("reset_quotient", Quotient, 0);
    chk("reset_remainder", Remainder, 0);
    chk("reset_divisor", Divisor, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    chk("reset_divzero", DivZero, 0);
    @(posedge Clk); #1;
    Reset = 1'b0;

    do_div(8'h07, 8'h64, 1'b0, 0, 1'b0);
    do_div(8'h00, 8'hC8, 1'b0, 0, 1'b0);
    reset_mid_iter();
    do_div(8'h10, 8'hFF, 1'b0, 0, 1'b0);
`ifdef DIV_SIGNED_EN
    do_div(8'h02, 8'hF9, 1'b0, 0, 1'b0);
    do_div(8'hFF, 8'h80, 1'b0, 0, 1'b0);
`endif
    do_div(8'h05, 8'hEE, 1'b0, 30, 1'b1);
    do_div(8'h00, 8'h09, 1'b1, 0, 1'b0);
    chk("simul_divisor", Divisor, 8'h09);
    do_div(8'h00, 8'h00, 1'b1, 0, 1'b0);
    do_div(8'h01, 8'hFF, 1'b0, 0, 1'b0);
    do_div(8'h05, 8'h00, 1'b0, 0, 1'b0);
    do_div(8'hFF, 8'hFF, 1'b0, 0, 1'b0);
    do_div(8'hFF, 8'h80, 1'b0, 0, 1'b0);
    do_div(8'h80, 8'h7F, 1'b0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      do_div(b, a, ($urandom_range(0, 7) == 0), 0, 1'b0);
    end

    repeat (3) @(negedge Clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
